// File: rtl/block_deinterleaver_pp.sv
// Ping-pong block deinterleaver: symbols written row-major into ROWS x COLS bit banks, drained column-major 1 bit/cycle; DEINT_OVERFLOW_EN adds a sticky overflow flag.
// Latency: out[0] valid one cycle after a bank fills; out_stall freezes data_out/read index, in_accept drops while both banks are occupied.
module block_deinterleaver_pp #(
    parameter int SYM_W = 4,
    parameter int ROWS  = 8,
    parameter int COLS  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             data_ready,
    input  logic [SYM_W-1:0] in_bits,
    output logic             in_accept,
    input  logic             out_stall,
    output logic             data_out,
    output logic             out_ready,
`ifdef DEINT_OVERFLOW_EN
    output logic             block_done,
    output logic             overflow
`else
    output logic             block_done
`endif
);

    localparam int N      = ROWS * COLS;
    localparam int NSYM   = N / SYM_W;
    localparam int WCNT_W = (NSYM > 1) ? $clog2(NSYM) : 1;
    localparam int RCNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_t;

    bank_state_t       bank_q [2];
    bank_state_t       bank_d [2];
    logic              wr_sel_q, wr_sel_d;
    logic              rd_sel_q, rd_sel_d;
    logic [WCNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [RCNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic              data_out_q, data_out_d;
    logic              out_ready_q, out_ready_d;
    logic              block_done_q, block_done_d;
    logic [N-1:0]      mem_q [2];

    logic              wr_en;
    logic [RCNT_W-1:0] wr_base;
    logic              rd_adv;
    logic              rd_last;

    // Column-major read index j maps to row-major storage address.
    function automatic logic [RCNT_W-1:0] rd_addr(input logic [RCNT_W-1:0] j);
        int ji;
        ji = 32'(j);
        return RCNT_W'((ji % ROWS) * COLS + ji / ROWS);
    endfunction

    always_comb begin
        bank_d       = bank_q;
        wr_sel_d     = wr_sel_q;
        rd_sel_d     = rd_sel_q;
        wr_cnt_d     = wr_cnt_q;
        rd_cnt_d     = rd_cnt_q;
        data_out_d   = data_out_q;
        out_ready_d  = out_ready_q;
        block_done_d = 1'b0;

        in_accept = !reset && (bank_q[wr_sel_q] == EMPTY || bank_q[wr_sel_q] == FILLING);
        wr_en     = data_ready && in_accept;
        wr_base   = RCNT_W'(32'(wr_cnt_q) * SYM_W);

        if (wr_en) begin
            if (wr_cnt_q == WCNT_W'(NSYM - 1)) begin
                bank_d[wr_sel_q] = FULL;
                wr_sel_d         = !wr_sel_q;
                wr_cnt_d         = '0;
            end else begin
                bank_d[wr_sel_q] = FILLING;
                wr_cnt_d         = wr_cnt_q + 1'b1;
            end
        end

        rd_adv  = out_ready_q && !out_stall;
        rd_last = rd_adv && (rd_cnt_q == RCNT_W'(N - 1));

        // The writer only touches EMPTY/FILLING banks and the reader only FULL/DRAINING ones.
        if (rd_last) begin
            bank_d[rd_sel_q] = EMPTY;
            rd_sel_d         = !rd_sel_q;
            rd_cnt_d         = '0;
            if (bank_q[!rd_sel_q] == FULL) begin
                bank_d[!rd_sel_q] = DRAINING;
                out_ready_d       = 1'b1;
                data_out_d        = mem_q[!rd_sel_q][rd_addr('0)];
            end else begin
                out_ready_d = 1'b0;
                data_out_d  = 1'b0;
            end
        end else if (rd_adv) begin
            rd_cnt_d   = rd_cnt_q + 1'b1;
            data_out_d = mem_q[rd_sel_q][rd_addr(rd_cnt_q + 1'b1)];
        end else if (!out_ready_q && bank_q[rd_sel_q] == FULL) begin
            bank_d[rd_sel_q] = DRAINING;
            out_ready_d      = 1'b1;
            data_out_d       = mem_q[rd_sel_q][rd_addr('0)];
        end

        block_done_d = out_ready_d && (rd_cnt_d == RCNT_W'(N - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bank_q[0]    <= EMPTY;
            bank_q[1]    <= EMPTY;
            wr_sel_q     <= 1'b0;
            rd_sel_q     <= 1'b0;
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            data_out_q   <= 1'b0;
            out_ready_q  <= 1'b0;
            block_done_q <= 1'b0;
        end else begin
            bank_q       <= bank_d;
            wr_sel_q     <= wr_sel_d;
            rd_sel_q     <= rd_sel_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            data_out_q   <= data_out_d;
            out_ready_q  <= out_ready_d;
            block_done_q <= block_done_d;
        end
    end

    // Bank storage needs no reset: bank state gates every read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < SYM_W; b++) begin
                mem_q[wr_sel_q][wr_base + RCNT_W'(b)] <= in_bits[SYM_W-1-b];
            end
        end
    end

    assign data_out   = data_out_q;
    assign out_ready  = out_ready_q;
    assign block_done = block_done_q;

`ifdef DEINT_OVERFLOW_EN
    logic overflow_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (data_ready && !in_accept) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_block_deinterleaver_pp.sv
// Directed bench for block_deinterleaver_pp at default parameters (SYM_W=4, ROWS=8, COLS=16).
module tb_block_deinterleaver_pp;

    localparam logic [127:0] PAT1 = 128'h3C3CC3C3CCCC3333C5AC368C0DDE3EFC;
    localparam logic [127:0] PAT2 = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [127:0] LAST = 128'd1 << 127;

    logic       clk        = 1'b0;
    logic       reset      = 1'b1;
    logic       data_ready = 1'b0;
    logic [3:0] in_bits    = 4'h0;
    logic       out_stall  = 1'b0;
    logic       in_accept;
    logic       data_out;
    logic       out_ready;
    logic       block_done;
`ifdef DEINT_OVERFLOW_EN
    logic       overflow;
`endif

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    bit got_q [$];
    bit done_q [$];
    int cyc_q [$];

    typedef struct {
        int k;
        int j_exp;
    } vec_t;
    vec_t tbl [7];

    block_deinterleaver_pp #(.SYM_W(4), .ROWS(8), .COLS(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .data_ready (data_ready),
        .in_bits    (in_bits),
        .in_accept  (in_accept),
        .out_stall  (out_stall),
        .data_out   (data_out),
        .out_ready  (out_ready),
`ifdef DEINT_OVERFLOW_EN
        .block_done (block_done),
        .overflow   (overflow)
`else
        .block_done (block_done)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Every bit consumed by the downstream side is logged with its cycle.
    always @(negedge clk) begin
        if (out_ready === 1'b1 && out_stall === 1'b0) begin
            got_q.push_back(data_out);
            done_q.push_back(block_done);
            cyc_q.push_back(cyc);
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk_v(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic chk_b(input string name, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b", name, act, exp);
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic timeout(input string name);
        n_chk++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        got_q.delete();
        done_q.delete();
        cyc_q.delete();
    endtask

    task automatic send_sym(input logic [3:0] sym);
        int guard;
        guard      = 0;
        data_ready = 1'b1;
        in_bits    = sym;
        #1;
        while (in_accept !== 1'b1 && guard < 400) begin
            step();
            guard++;
        end
        if (guard >= 400) timeout("send_sym accept");
        step();
        data_ready = 1'b0;
    endtask

    task automatic send_block(input logic [127:0] blk);
        for (int s = 0; s < 32; s++) send_sym(blk[127-4*s -: 4]);
    endtask

    task automatic wait_bits(input int n, input string name);
        int g;
        g = 0;
        while (got_q.size() < n && g < 2000) begin
            step();
            g++;
        end
        if (g >= 2000) timeout(name);
    endtask

    function automatic logic [127:0] qvec(input int base);
        logic [127:0] v;
        v = '0;
        for (int j = 0; j < 128; j++) if (base + j < got_q.size()) v[j] = got_q[base+j];
        return v;
    endfunction

    function automatic logic [127:0] dvec(input int base);
        logic [127:0] v;
        v = '0;
        for (int j = 0; j < 128; j++) if (base + j < done_q.size()) v[j] = done_q[base+j];
        return v;
    endfunction

    // Bit j of the result is out[j]; input bit k is blk[127-k].
    function automatic logic [127:0] deint(input logic [127:0] blk);
        logic [127:0] r;
        for (int j = 0; j < 128; j++) r[j] = blk[127 - ((j % 8) * 16 + j / 8)];
        return r;
    endfunction

    initial begin
        logic [127:0] exp1;
        logic [127:0] exp2;
        int           stall_bad;
        int           acc_seen;
        int           n_after;

        tbl[0] = '{17, 9};
        tbl[1] = '{0, 0};
        tbl[2] = '{127, 127};
        tbl[3] = '{1, 8};
        tbl[4] = '{16, 1};
        tbl[5] = '{15, 120};
        tbl[6] = '{112, 7};
        exp1 = deint(PAT1);
        exp2 = deint(PAT2);

        repeat (3) step();
        chk_b("reset out_ready", out_ready, 1'b0);
        chk_b("reset data_out", data_out, 1'b0);
        chk_b("reset block_done", block_done, 1'b0);
        chk_b("in_accept during reset", in_accept, 1'b0);
`ifdef DEINT_OVERFLOW_EN
        chk_b("reset overflow", overflow, 1'b0);
`endif
        reset = 1'b0;
        #1;
        chk_b("in_accept after reset", in_accept, 1'b1);
        step();

        // Single-bit blocks: bit k of the input must surface only at out[j_exp].
        for (int i = 0; i < 7; i++) begin
            clear_log();
            send_block(128'd1 << (127 - tbl[i].k));
            chk_b($sformatf("latency T k=%0d", tbl[i].k), out_ready, 1'b0);
            step();
            chk_b($sformatf("latency T+1 k=%0d", tbl[i].k), out_ready, 1'b1);
            wait_bits(128, "single drain");
            chk_v($sformatf("single map k=%0d", tbl[i].k), qvec(0), 128'd1 << tbl[i].j_exp);
            chk_v($sformatf("single done k=%0d", tbl[i].k), dvec(0), LAST);
            repeat (3) step();
        end

        clear_log();
        send_block(PAT1);
        chk_b("full latency T", out_ready, 1'b0);
        step();
        chk_b("full latency T+1", out_ready, 1'b1);
        chk_b("full out[0]", data_out, exp1[0]);
        wait_bits(128, "full drain");
        chk_v("full map", qvec(0), exp1);
        chk_v("full done", dvec(0), LAST);
        chk_i("full unstalled length", cyc_q[127] - cyc_q[0], 127);
        repeat (3) step();

        // Back-to-back blocks, then a third block offered while both banks are busy.
        clear_log();
        send_block(PAT1);
        send_block(PAT2);
        acc_seen   = 0;
        data_ready = 1'b1;
        in_bits    = 4'hF;
        repeat (3) begin
            if (in_accept !== 1'b0) acc_seen++;
            step();
        end
        data_ready = 1'b0;
        chk_i("both busy in_accept high count", acc_seen, 0);
`ifdef DEINT_OVERFLOW_EN
        chk_b("overflow set", overflow, 1'b1);
`endif
        wait_bits(256, "b2b drain");
        chk_v("b2b block A", qvec(0), exp1);
        chk_v("b2b block B", qvec(128), exp2);
        chk_i("b2b contiguous span", cyc_q[255] - cyc_q[0], 255);
        chk_v("b2b done A", dvec(0), LAST);
        chk_v("b2b done B", dvec(128), LAST);
        repeat (3) step();
        chk_b("b2b idle out_ready", out_ready, 1'b0);
`ifdef DEINT_OVERFLOW_EN
        chk_b("overflow sticky", overflow, 1'b1);
`endif

        // Five stall cycles at j=40.
        clear_log();
        send_block(PAT2);
        wait_bits(40, "stall approach");
        chk_b("stall j40 presented", data_out, exp2[40]);
        out_stall = 1'b1;
        stall_bad = 0;
        repeat (5) begin
            step();
            if (data_out !== exp2[40] || out_ready !== 1'b1) stall_bad++;
        end
        out_stall = 1'b0;
        chk_i("stall hold errors", stall_bad, 0);
        chk_i("stall no bits consumed", got_q.size(), 40);
        wait_bits(128, "stall drain");
        chk_v("stall data", qvec(0), exp2);
        chk_i("stall drain span", cyc_q[127] - cyc_q[0], 132);
        chk_v("stall done", dvec(0), LAST);
        repeat (3) step();

        // One-cycle reset while j=60 is presented.
        clear_log();
        send_block(PAT1);
        wait_bits(60, "reset approach");
        reset = 1'b1;
        #1;
        chk_b("mid reset in_accept", in_accept, 1'b0);
        step();
        reset = 1'b0;
        chk_b("post reset out_ready", out_ready, 1'b0);
        chk_b("post reset data_out", data_out, 1'b0);
        chk_b("post reset block_done", block_done, 1'b0);
`ifdef DEINT_OVERFLOW_EN
        chk_b("post reset overflow", overflow, 1'b0);
`endif
        #1;
        chk_b("post reset in_accept", in_accept, 1'b1);
        n_after = got_q.size();
        repeat (150) step();
        chk_i("bits before reset", n_after, 61);
        chk_i("no bits after reset", got_q.size(), 61);
        clear_log();
        send_block(PAT2);
        step();
        chk_b("fresh latency", out_ready, 1'b1);
        wait_bits(128, "fresh drain");
        chk_v("fresh map", qvec(0), exp2);
        chk_v("fresh done", dvec(0), LAST);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/block_deinterleaver_pp.md
# block_deinterleaver_pp

Parametrised ping-pong block deinterleaver for the receive chain. It accepts `SYM_W`-bit symbols from the demapper and writes them row-major into a `ROWS`×`COLS` bit matrix. It then emits the matrix serially, one bit per cycle, column-major, to the downstream decoder. Two banks let one block load while the previous block drains, and the output supports stall-based backpressure.

## Interface
- `SYM_W`, default 4: bits per input symbol; `ROWS*COLS` must be a multiple of `SYM_W`.
- `ROWS`, default 8: matrix rows.
- `COLS`, default 16: matrix columns. Block size is `N = ROWS*COLS` bits (default 128).
- `clk` input, 1: the only clock; all logic is on its rising edge.
- `reset` input, 1: synchronous, active-high. Fixed; no other reset.
- `data_ready` input, 1: `in_bits` is valid this cycle.
- `in_bits` input, `SYM_W`: input symbol; MSB is the earliest bit.
- `in_accept` output, 1: the block can take a symbol this cycle.
- `out_stall` input, 1: downstream cannot take `data_out` this cycle.
- `data_out` output, 1: deinterleaved serial bit.
- `out_ready` output, 1: `data_out` is valid.
- `block_done` output, 1: one-cycle pulse, high together with the last bit of a block.
- `overflow` output, 1: sticky flag, present only under `DEINT_OVERFLOW_EN`.

## Operation
- **Input bit index:** `k = 0..N-1`. For symbol `s`, `in_bits[SYM_W-1-b]` is bit `k = s*SYM_W + b`.
- **Write mapping:** bit `k` is stored at row `k / COLS`, column `k % COLS`.
- **Read mapping:** output index `j` reads column `j / ROWS`, row `j % ROWS`. So `out[j] = in[(j % ROWS)*COLS + j / ROWS]`.
- **Bank states:** each bank is EMPTY, FILLING, FULL or DRAINING.
- **Bank pointers:** `wr_sel` and `rd_sel` are both 0 after reset.
- **Writer:**
  - Accepts a symbol on an edge where `data_ready && in_accept`.
  - The first accepted symbol moves an EMPTY bank to FILLING.
  - The symbol that completes `N` bits moves the bank to FULL and toggles `wr_sel`.
- **`in_accept`:** equals `!reset && (bank[wr_sel]` is EMPTY or FILLING`)`.
- **Reader:**
  - When `bank[rd_sel]` is FULL, it enters DRAINING and presents bit `j=0`.
  - On each edge with `out_ready && !out_stall`, `j` advances.
  - On the edge that consumes `j=N-1`, the bank goes to EMPTY and `rd_sel` toggles.
- **Back-to-back blocks:** if the other bank is already FULL when a bank finishes draining, its bit 0 is presented on the next cycle. There is no bubble.
- **Overflow:** a symbol presented with `data_ready=1` while `in_accept=0` is dropped. No memory or counter changes.
- **Counters:** write counter is `$clog2(N/SYM_W)` bits and read counter is `$clog2(N)` bits; both wrap to 0 at block end.

## Timing
- **Reset values:** `data_out=0`, `out_ready=0`, `block_done=0`, `overflow=0`. Both banks are EMPTY and both counters are 0. `in_accept` is 0 while `reset=1`.
- **Reset mid-block:** discards all partial and full blocks, with outputs at their reset values on the following cycle. No bit of a discarded block may appear after reset.
- **Latency:** the last symbol of a block is accepted at edge T. If the reader is idle, `out_ready=1` with `out[0]` is visible after edge T+1.
- **Unstalled drain:** takes exactly `N` consecutive cycles.
- **Output registers:** `data_out` and `out_ready` are registered.
- **Holding under stall:** `data_out` holds its value while `out_stall=1`.
- **`block_done`:** high exactly in the cycle `out[N-1]` is valid. It stays high under stall until that bit is consumed.
- **Simultaneous write and read:** completing a write into one bank on the same edge the other bank finishes draining is legal. Both transitions take effect.
- **Full stall:** with both banks FULL or DRAINING, `in_accept=0`.

## Configuration
- **`DEINT_OVERFLOW_EN` defined:** the `overflow` port exists. It goes to 1 on the edge after any dropped symbol and clears only on `reset`.
- **Without the macro:** the port and its logic are absent. Dropped symbols are silently discarded, and the datapath behaviour is otherwise identical.

## Test plan
All scenarios use the defaults `SYM_W=4`, `ROWS=8`, `COLS=16`.
- **Single-bit mapping:** block with only `k=17` set (symbol 4 = `4'b0100`, all others 0). Expect exactly `out[9]=1` and all other 127 bits 0. `out_ready` rises one cycle after the 32nd accepted symbol.
- **Full-block mapping:** block `128'h3C3CC3C3CCCC3333C5AC368C0DDE3EFC`, MSB first. Check all 128 output bits against `out[j] = in[(j%8)*16 + j/8]`. `block_done` is high only with bit 127.
- **Back-to-back:** two blocks driven continuously with `data_ready` held at 1. The second block loads during the first drain, and `in_accept` drops while both banks are occupied. Output is 256 contiguous valid cycles with no gap.
- **Backpressure:** `out_stall` asserted for 5 cycles at `j=40`. `data_out` and `j` hold for those 5 cycles, nothing is lost, and the total drain takes 133 cycles.
- **Reset mid-drain:** `reset` asserted for one cycle at `j=60`. The next cycle shows `out_ready=0`, `in_accept=1`, and no further bits appear. A fresh block then deinterleaves correctly.
- **Overflow (`DEINT_OVERFLOW_EN`):** third block presented while both banks are busy. `overflow` goes to 1 and stays there, and the first two blocks are output unchanged.
